// File: rtl/vga_rx_monitor.sv
// Receive-side timing checker and pixel sampler for a VGA stream: rebuilds the
// pixel position from sync edges, qualifies timing lock and captures one probe pixel.
module vga_rx_monitor #(
  parameter int H_TOTAL     = 800,
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int H_ACTIVE    = 640,
  parameter int V_TOTAL     = 525,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 33,
  parameter int V_ACTIVE    = 480,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hs,
  input  logic        vs,
  input  logic [3:0]  r,
  input  logic [3:0]  g,
  input  logic [3:0]  b,
  input  logic [9:0]  probe_x,
  input  logic [9:0]  probe_y,
  input  logic        err_clr,
  output logic        locked,
  output logic [11:0] cap_rgb,
  output logic        cap_valid,
  output logic        err_hline,
  output logic        err_hsync,
  output logic        err_vframe,
  output logic        err_vsync,
  output logic [15:0] frame_cnt
);

  typedef enum logic [1:0] {UNLOCKED, SYNCING, LOCKED} state_e;

  localparam logic [10:0] HTOT   = 11'(H_TOTAL);
  localparam logic [10:0] HSYNC  = 11'(H_SYNC);
  localparam logic [10:0] HSTART = 11'(H_SYNC + H_BACK);
  localparam logic [10:0] HEND   = 11'(H_SYNC + H_BACK + H_ACTIVE);
  localparam logic [9:0]  VTOT   = 10'(V_TOTAL);
  localparam logic [9:0]  VSYNC  = 10'(V_SYNC);
  localparam logic [9:0]  VSTART = 10'(V_SYNC + V_BACK);
  localparam logic [9:0]  VEND   = 10'(V_SYNC + V_BACK + V_ACTIVE);
  localparam logic [7:0]  LOCK_N = 8'(LOCK_FRAMES);

  state_e      state_q, state_d;
  logic        hs_q, vs_q, vs_armed_q, vs_armed_d;
  logic        h_ref_q, h_ref_d, v_ref_q, v_ref_d;
  logic        err_since_q, err_since_d;
  logic [7:0]  good_cnt_q, good_cnt_d;
  logic [10:0] hpos_q, hpos_d, x;
  logic [9:0]  vpos_q, vpos_d, vs_lines_q, vs_lines_d, y;
  logic        err_hline_q, err_hsync_q, err_vframe_q, err_vsync_q;
  logic [15:0] frame_cnt_q;
  logic [11:0] cap_rgb_q;
  logic        cap_valid_q;
  logic        hs_fall, hs_rise, vs_fall, vs_rise, frame_start;
  logic        e_hline, e_hsync, e_vframe, e_vsync, err_now, in_lock;
  logic        active, cap_fire;

  assign hs_fall     = hs_q & ~hs;
  assign hs_rise     = ~hs_q & hs;
  assign vs_fall     = vs_q & ~vs;
  assign vs_rise     = ~vs_q & vs;
  assign frame_start = hs_fall & ~vs & vs_armed_q;
  assign in_lock     = (state_q == LOCKED);

  // Position of the current sample plus the timing checks it triggers.
  always_comb begin
    hpos_d     = hs_fall ? 11'd0 : ((hpos_q == 11'h7FF) ? hpos_q : hpos_q + 11'd1);
    vpos_d     = vpos_q;
    vs_lines_d = vs_lines_q;
    vs_armed_d = frame_start ? 1'b0 : (vs | vs_armed_q);
    if (frame_start)
      vpos_d = 10'd0;
    else if (hs_fall && vpos_q != 10'h3FF)
      vpos_d = vpos_q + 10'd1;
    if (vs_fall)
      vs_lines_d = {9'd0, hs_fall};
    else if (!vs && hs_fall && vs_lines_q != 10'h3FF)
      vs_lines_d = vs_lines_q + 10'd1;
    e_hline  = hs_fall & h_ref_q & ((hpos_q + 11'd1) != HTOT);
    e_hsync  = hs_rise & (hpos_d != HSYNC);
    e_vsync  = vs_rise & (vs_lines_q != VSYNC);
    e_vframe = frame_start & v_ref_q & ((vpos_q + 10'd1) != VTOT);
    err_now  = e_hline | e_hsync | e_vframe | e_vsync;
    x        = hpos_d - HSTART;
    y        = vpos_d - VSTART;
    active   = (hpos_d >= HSTART) && (hpos_d < HEND) && (vpos_d >= VSTART) && (vpos_d < VEND);
    cap_fire = in_lock & active & (x == {1'b0, probe_x}) & (y == probe_y);
  end

  // Sync history resets high (idle level) so reset release never fabricates an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_q         <= 1'b1;
      vs_q         <= 1'b1;
      vs_armed_q   <= 1'b0;
      hpos_q       <= '0;
      vpos_q       <= '0;
      vs_lines_q   <= '0;
      err_hline_q  <= 1'b0;
      err_hsync_q  <= 1'b0;
      err_vframe_q <= 1'b0;
      err_vsync_q  <= 1'b0;
      frame_cnt_q  <= '0;
      cap_rgb_q    <= '0;
      cap_valid_q  <= 1'b0;
    end else begin
      hs_q         <= hs;
      vs_q         <= vs;
      vs_armed_q   <= vs_armed_d;
      hpos_q       <= hpos_d;
      vpos_q       <= vpos_d;
      vs_lines_q   <= vs_lines_d;
      err_hline_q  <= (in_lock & e_hline)  | (~err_clr & err_hline_q);
      err_hsync_q  <= (in_lock & e_hsync)  | (~err_clr & err_hsync_q);
      err_vframe_q <= (in_lock & e_vframe) | (~err_clr & err_vframe_q);
      err_vsync_q  <= (in_lock & e_vsync)  | (~err_clr & err_vsync_q);
      if (in_lock && frame_start)
        frame_cnt_q <= frame_cnt_q + 16'd1;
      if (cap_fire)
        cap_rgb_q <= {r, g, b};
      cap_valid_q  <= cap_fire;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= UNLOCKED;
      good_cnt_q  <= '0;
      err_since_q <= 1'b0;
      h_ref_q     <= 1'b0;
      v_ref_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      good_cnt_q  <= good_cnt_d;
      err_since_q <= err_since_d;
      h_ref_q     <= h_ref_d;
      v_ref_q     <= v_ref_d;
    end
  end

  // A frame counts as clean only if no error was seen since the previous frame start.
  always_comb begin
    state_d     = state_q;
    good_cnt_d  = good_cnt_q;
    err_since_d = err_since_q;
    h_ref_d     = h_ref_q | hs_fall;
    v_ref_d     = v_ref_q | frame_start;
    case (state_q)
      UNLOCKED: begin
        if (frame_start) begin
          state_d     = SYNCING;
          good_cnt_d  = '0;
          err_since_d = 1'b0;
        end
      end
      SYNCING: begin
        if (frame_start) begin
          err_since_d = 1'b0;
          if (err_now || err_since_q)
            good_cnt_d = '0;
          else begin
            good_cnt_d = good_cnt_q + 8'd1;
            if (good_cnt_q + 8'd1 >= LOCK_N)
              state_d = LOCKED;
          end
        end else if (err_now) begin
          good_cnt_d  = '0;
          err_since_d = 1'b1;
        end
      end
      LOCKED: begin
        if (err_now) begin
          state_d    = UNLOCKED;
          good_cnt_d = '0;
          h_ref_d    = 1'b0;
          v_ref_d    = 1'b0;
        end
      end
      default: state_d = UNLOCKED;
    endcase
  end

  always_comb begin
    locked     = (state_q == LOCKED);
    cap_rgb    = cap_rgb_q;
    cap_valid  = cap_valid_q;
    err_hline  = err_hline_q;
    err_hsync  = err_hsync_q;
    err_vframe = err_vframe_q;
    err_vsync  = err_vsync_q;
    frame_cnt  = frame_cnt_q;
  end

endmodule

// File: tb/tb_vga_rx_monitor.sv
// Directed bench for vga_rx_monitor on a shrunken raster; captures are checked
// against a queue of expected colours and strobe cycles.
module tb_vga_rx_monitor;

  localparam int HT = 20, HS = 3, HB = 2, HA = 12;
  localparam int VT = 16, VS = 2, VB = 2, VA = 10;

  logic        clk = 1'b0;
  logic        rst_n, hs, vs, err_clr;
  logic [3:0]  r, g, b;
  logic [9:0]  probe_x, probe_y;
  logic        locked, cap_valid, err_hline, err_hsync, err_vframe, err_vsync;
  logic [11:0] cap_rgb;
  logic [15:0] frame_cnt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int capSeen = 0;
  int expCycQ[$];
  logic [11:0] expRgbQ[$];

  vga_rx_monitor #(
    .H_TOTAL(HT), .H_SYNC(HS), .H_BACK(HB), .H_ACTIVE(HA),
    .V_TOTAL(VT), .V_SYNC(VS), .V_BACK(VB), .V_ACTIVE(VA), .LOCK_FRAMES(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .hs(hs), .vs(vs), .r(r), .g(g), .b(b),
    .probe_x(probe_x), .probe_y(probe_y), .err_clr(err_clr),
    .locked(locked), .cap_rgb(cap_rgb), .cap_valid(cap_valid),
    .err_hline(err_hline), .err_hsync(err_hsync), .err_vframe(err_vframe),
    .err_vsync(err_vsync), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] errFlags();
    return {12'd0, err_hline, err_hsync, err_vframe, err_vsync};
  endfunction

  // Every strobe must match the oldest queued capture in both colour and cycle.
  always @(posedge clk) begin
    #1;
    if (cap_valid === 1'b1) begin
      capSeen++;
      if (expCycQ.size() == 0)
        checkOutput("capSpurious", 16'(cap_valid), 16'h0);
      else begin
        checkOutput("capCycle", 16'(cyc), 16'(expCycQ.pop_front()));
        checkOutput("capRgb", 16'(cap_rgb), 16'(expRgbQ.pop_front()));
      end
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      hs = 1'b1;
      vs = 1'b1;
      err_clr = 1'b0;
      {r, g, b} = 12'h000;
    end
  endtask

  // One frame of raster; hs/vs fall at the first sample, pixel marked at the probe.
  task automatic applyStimulus(input int nLines, input int shortLine, input int hsBadLine,
                               input int vsLen, input bit clrFirst, input bit expectCap,
                               input int rstLine, input int rstPix);
    int len, hsw, pl, pp;
    pl = VS + VB + int'(probe_y);
    pp = HS + HB + int'(probe_x);
    for (int l = 0; l < nLines; l++) begin
      len = (l == shortLine) ? HT - 1 : HT;
      hsw = (l == hsBadLine) ? HS - 1 : HS;
      for (int p = 0; p < len; p++) begin
        @(negedge clk);
        hs = (p >= hsw);
        vs = (l >= vsLen);
        err_clr = clrFirst && (l == 0) && (p == 0);
        if (l == pl && p == pp) begin
          {r, g, b} = 12'hA5C;
          if (expectCap) begin
            expCycQ.push_back(cyc + 1);
            expRgbQ.push_back(12'hA5C);
          end
        end else
          {r, g, b} = 12'h000;
        if (l == rstLine && p == rstPix) begin
          #2 rst_n = 1'b0;
          #1;
          checkOutput("rstLocked", 16'(locked), 16'h0);
          checkOutput("rstCapValid", 16'(cap_valid), 16'h0);
          checkOutput("rstErr", errFlags(), 16'h0);
          checkOutput("rstFrameCnt", frame_cnt, 16'h0);
          return;
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; hs = 1'b1; vs = 1'b1; err_clr = 1'b0;
    {r, g, b} = 12'h000;
    probe_x = 10'd5; probe_y = 10'd7;
    repeat (3) @(negedge clk);
    checkOutput("resetLocked", 16'(locked), 16'h0);
    checkOutput("resetCapValid", 16'(cap_valid), 16'h0);
    checkOutput("resetCapRgb", 16'(cap_rgb), 16'h0);
    checkOutput("resetErr", errFlags(), 16'h0);
    checkOutput("resetFrameCnt", frame_cnt, 16'h0);
    rst_n = 1'b1;
    idle(4);

    applyStimulus(VT, -1, -1, VS, 1'b0, 1'b0, -1, -1);
    applyStimulus(VT, -1, -1, VS, 1'b0, 1'b0, -1, -1);
    checkOutput("lockAfter2", 16'(locked), 16'h0);
    applyStimulus(VT, -1, -1, VS, 1'b0, 1'b1, -1, -1);
    checkOutput("lockAfter3", 16'(locked), 16'h1);
    checkOutput("cleanErr", errFlags(), 16'h0);
    checkOutput("frameCnt0", frame_cnt, 16'h0);
    applyStimulus(VT, -1, -1, VS, 1'b0, 1'b1, -1, -1);
    checkOutput("frameCnt1", frame_cnt, 16'h1);
    checkOutput("capHold", 16'(cap_rgb), 16'hA5C);

    probe_y = 10'd10;
    applyStimulus(VT, -1, -1, VS, 1'b0, 1'b0, -1, -1);
    checkOutput("oorNoCap", 16'(capSeen), 16'd2);
    checkOutput("frameCnt2", frame_cnt, 16'h2);
    probe_y = 10'd7;

    applyStimulus(VT, 6, -1, VS, 1'b0, 1'b0, -1, -1);
    checkOutput("hlineErr", errFlags(), 16'h8);
    checkOutput("hlineUnlock", 16'(locked), 16'h0);
    applyStimulus(VT, -1, -1, VS, 1'b0, 1'b0, -1, -1);
    applyStimulus(VT, -1, -1, VS, 1'b0, 1'b0, -1, -1);
    applyStimulus(VT, -1, -1, VS, 1'b0, 1'b1, -1, -1);
    checkOutput("relock1", 16'(locked), 16'h1);
    checkOutput("hlineSticky", errFlags(), 16'h8);
    checkOutput("frameCnt3", frame_cnt, 16'h3);

    applyStimulus(VT, -1, 3, VS, 1'b0, 1'b0, -1, -1);
    checkOutput("hsyncErr", errFlags(), 16'hC);
    checkOutput("hsyncUnlock", 16'(locked), 16'h0);
    applyStimulus(VT, -1, -1, VS, 1'b0, 1'b0, -1, -1);
    applyStimulus(VT, -1, -1, VS, 1'b0, 1'b0, -1, -1);
    applyStimulus(VT, -1, -1, VS, 1'b0, 1'b1, -1, -1);
    checkOutput("relock2", 16'(locked), 16'h1);

    applyStimulus(VT, -1, -1, VS + 1, 1'b0, 1'b0, -1, -1);
    checkOutput("vsyncErr", errFlags(), 16'hD);
    checkOutput("vsyncUnlock", 16'(locked), 16'h0);
    applyStimulus(VT, -1, -1, VS, 1'b0, 1'b0, -1, -1);
    applyStimulus(VT, -1, -1, VS, 1'b0, 1'b0, -1, -1);
    applyStimulus(VT, -1, -1, VS, 1'b0, 1'b1, -1, -1);
    checkOutput("relock3", 16'(locked), 16'h1);
    checkOutput("noVframeErr", errFlags(), 16'hD);

    applyStimulus(VT - 1, -1, -1, VS, 1'b0, 1'b1, -1, -1);
    applyStimulus(VT, -1, -1, VS, 1'b1, 1'b0, -1, -1);
    checkOutput("clrSetRace", errFlags(), 16'h2);
    checkOutput("vframeUnlock", 16'(locked), 16'h0);
    applyStimulus(VT, -1, -1, VS, 1'b0, 1'b0, -1, -1);
    applyStimulus(VT, -1, -1, VS, 1'b0, 1'b0, -1, -1);
    applyStimulus(VT, -1, -1, VS, 1'b0, 1'b1, -1, -1);
    checkOutput("relock4", 16'(locked), 16'h1);
    checkOutput("frameCnt7", frame_cnt, 16'h7);

    applyStimulus(VT, -1, -1, VS, 1'b0, 1'b1, 9, 10);
    hs = 1'b1; vs = 1'b1; {r, g, b} = 12'h000;
    idle(2);
    rst_n = 1'b1;
    idle(4);
    applyStimulus(VT, -1, -1, VS, 1'b0, 1'b0, -1, -1);
    applyStimulus(VT, -1, -1, VS, 1'b0, 1'b0, -1, -1);
    checkOutput("postRstNoLock", 16'(locked), 16'h0);
    applyStimulus(VT, -1, -1, VS, 1'b0, 1'b1, -1, -1);
    checkOutput("postRstLock", 16'(locked), 16'h1);

    idle(3);
    checkOutput("capQueueEmpty", 16'(expCycQ.size()), 16'h0);
    checkOutput("capCount", 16'(capSeen), 16'd8);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_rx_monitor.md
Name: vga_rx_monitor

Overview:
- Receive-side checker and sampler for the VGA stream that the top-level design drives out (hs, vs, 4:4:4 RGB, 640x480@60, 25 MHz pixel clock).
- Tracks sync edges and rebuilds the horizontal and vertical pixel position.
- Validates line, frame and sync-pulse timing, declares lock, and captures the colour at a programmable probe coordinate.
- Used in simulation benches and as an on-board debug tap in front of the video outputs.

Parameters:
- H_TOTAL, 800, pixel clocks per line
- H_SYNC, 96, hs low width in clocks
- H_BACK, 48, back porch in clocks
- H_ACTIVE, 640, visible pixels per line
- V_TOTAL, 525, lines per frame
- V_SYNC, 2, vs low width in lines
- V_BACK, 33, back porch in lines
- V_ACTIVE, 480, visible lines
- LOCK_FRAMES, 2, consecutive clean frames required to lock

Ports:
- clk  in  1  pixel clock, one sample per rising edge
- rst_n  in  1  reset
- hs  in  1  horizontal sync, active low
- vs  in  1  vertical sync, active low
- r  in  4  red
- g  in  4  green
- b  in  4  blue
- probe_x  in  10  capture column, 0..H_ACTIVE-1
- probe_y  in  10  capture row, 0..V_ACTIVE-1
- err_clr  in  1  clears sticky error flags
- locked  out  1  timing lock achieved
- cap_rgb  out  12  captured colour as {r,g,b}
- cap_valid  out  1  one-cycle strobe when cap_rgb updates
- err_hline  out  1  sticky: wrong line length
- err_hsync  out  1  sticky: wrong hs pulse width
- err_vframe  out  1  sticky: wrong frame length
- err_vsync  out  1  sticky: wrong vs pulse width
- frame_cnt  out  16  locked frames seen, wraps at 65535

Behaviour:
- Clock and reset: single clock clk. Reset rst_n is asynchronous and active-low.
- Reset values: every output is 0, state is UNLOCKED, all counters and reference-valid flags are 0. Asserting reset mid-frame drops lock immediately, with no waiting for a clock edge.
- Edge detection: hs and vs are registered once as hs_q and vs_q. hs_fall = hs_q & ~hs. hs_rise = ~hs_q & hs. vs_fall and vs_rise are defined the same way.
- hpos, 11 bits:
  - 0 on a sample with hs_fall; otherwise hpos+1, saturating at 2047.
  - On hs_fall with h_ref set: error if old hpos+1 != H_TOTAL.
  - On hs_rise: error if hpos != H_SYNC.
  - h_ref is set on the first hs_fall.
- vs_lines: counts hs_fall samples while vs is low. It clears on vs_fall, before that sample's hs_fall is counted. On vs_rise: error if vs_lines != V_SYNC.
- vpos, 10 bits:
  - 0 on the first hs_fall sampled with vs low after vs was high (frame start).
  - On every other hs_fall, vpos+1, saturating.
  - At frame start with v_ref set: error if old vpos+1 != V_TOTAL.
  - v_ref is set at the first frame start.
- Active window:
  - hpos in [H_SYNC+H_BACK, H_SYNC+H_BACK+H_ACTIVE) and vpos in [V_SYNC+V_BACK, V_SYNC+V_BACK+V_ACTIVE).
  - x = hpos-(H_SYNC+H_BACK), y = vpos-(V_SYNC+V_BACK).
- FSM:
  - UNLOCKED -> SYNCING on the first frame start.
  - SYNCING: each frame start with no error since the previous frame start increments good_cnt. When good_cnt reaches LOCK_FRAMES, go to LOCKED. Any error clears good_cnt and stays in SYNCING.
  - LOCKED: any error -> UNLOCKED, clears good_cnt, h_ref and v_ref.
- Error flags: set only when the error is detected in LOCKED. They are sticky until err_clr. If err_clr and a new error land in the same cycle, set wins.
- Lock output: locked is registered and equals (state==LOCKED). It goes high on the clock after the qualifying frame start.
- Frame counter: frame_cnt increments at each frame start while in LOCKED, wraps modulo 2^16, and holds when not locked.
- Capture:
  - Fires when locked, the sample is active, and x==probe_x and y==probe_y: cap_rgb <= {r,g,b} and cap_valid=1 for exactly one cycle.
  - Latency is 1 clock after the sampled pixel; at most once per frame.
  - Out-of-range probe coordinates never fire.
  - A probe_x/probe_y change takes effect on the next sample.

Test Plan:
- Clean stream, 3 frames of ideal 800x525 timing, hs/vs low first at hpos/vpos 0 -> locked rises 1 clk after the 3rd frame start (LOCK_FRAMES=2 clean frames); all err_* = 0; frame_cnt = 0 until the next frame start, then 1.
- Probe: probe_x=5, probe_y=7, pixel (5,7) driven as r=A, g=5, b=C, all other pixels 0 -> cap_rgb=12'hA5C; cap_valid high for exactly 1 cycle, 1 clk after that pixel, once per frame.
- Line error: while locked, shorten one line to 799 clks -> err_hline=1 and locked=0 on the next clock. Three further clean frames relock; err_hline remains 1 until err_clr pulses.
- Sync width errors: while locked, hs low for 95 clks -> err_hsync=1. On a fresh lock, vs low for 3 lines -> err_vsync=1; the following frame start has the correct length, so err_vframe stays 0.
- Clear/set race: pulse err_clr in the same cycle a frame-length error is detected while locked -> err_vframe=1 (set wins).
- Reset mid-frame: assert rst_n=0 asynchronously at pixel (300,200) while locked -> locked, cap_valid, all err_* and frame_cnt are 0 before the next clk edge. After release, relock takes 3 frame starts.
